// File: rtl/seri_carpici_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seri_carpici_pkg
//  Description : Shared constants and FSM state encoding for the serial
//                4x4 shift-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package seri_carpici_pkg;

   // Operand width; the datapath is built around the 4-bit ripple adder.
   localparam int unsigned c_width = 4;

   // Value of the step counter on the last of the four CALC cycles.
   localparam logic [1:0] c_last_step = 2'd3;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : seri_carpici_pkg
`default_nettype wire

// File: rtl/seri_carpici_toplayici4bit.sv
`default_nettype none
// ============================================================================
//  Module      : toplayici4bit
//  Description : 4-bit ripple-carry adder, purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module toplayici4bit
   import seri_carpici_pkg::*;
(
   input  logic [c_width-1:0] a,
   input  logic [c_width-1:0] b,
   input  logic               cin,
   output logic [c_width-1:0] s,
   output logic               cout
);

   // Carry chain; w_c[0] is the carry-in, w_c[c_width] the carry-out.
   logic [c_width:0] w_c;

   assign w_c[0] = cin;

   generate
      for (genvar i = 0; i < c_width; i++) begin : g_fa
         assign s[i]       = a[i] ^ b[i] ^ w_c[i];
         assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout = w_c[c_width];

endmodule : toplayici4bit
`default_nettype wire

// File: rtl/seri_carpici.sv
`default_nettype none
// ============================================================================
//  Module      : seri_carpici
//  Description : Serial unsigned 4x4 shift-add multiplier. One accepted start
//                runs four CALC steps, then pulses done with the 8-bit
//                product on P. P only changes on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module seri_carpici
   import seri_carpici_pkg::*;
#(
   parameter int W = c_width
)
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   output logic [2*W-1:0] P,
   output logic           busy,
   output logic           done
);

   state_t         state_q, state_d;
   logic [W-1:0]   m_q, m_d;        // multiplicand
   logic [W-1:0]   l_q, l_d;        // multiplier / low product half
   logic [W-1:0]   h_q, h_d;        // high product half (partial sum)
   logic [1:0]     cnt_q, cnt_d;    // CALC step counter
   logic [2*W-1:0] p_q, p_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   // Adder operands: the multiplicand is added only when the current
   // multiplier bit (L[0]) is set.
   logic [W-1:0]   w_addend;
   logic [W-1:0]   w_sum;
   logic           w_carry;

   assign w_addend = m_q & {W{l_q[0]}};

   toplayici4bit u_adder (
      .a    (h_q),
      .b    (w_addend),
      .cin  (1'b0),
      .s    (w_sum),
      .cout (w_carry)
   );

   // Next-state and datapath update for the shift-add sequence.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      l_d     = l_q;
      h_d     = h_q;
      cnt_d   = cnt_q;
      p_d     = p_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CALC;
               m_d     = A;
               l_d     = B;
               h_d     = '0;
               cnt_d   = '0;
            end
         end
         CALC: begin
            // Shift {carry,sum} right one place into the H:L pair.
            h_d   = {w_carry, w_sum[W-1:1]};
            l_d   = {w_sum[0], l_q[W-1:1]};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == c_last_step) begin
               state_d = DONE;
               p_d     = {h_d, l_d};
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered copies of the next state.
      busy_d = (state_d == CALC);
      done_d = (state_d == DONE);
   end

   // State, datapath and output registers; asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         l_q     <= '0;
         h_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         l_q     <= l_d;
         h_q     <= h_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign P    = p_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule : seri_carpici
`default_nettype wire

// File: tb/tb_seri_carpici.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seri_carpici
//  Description : Self-checking bench for the serial 4x4 multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seri_carpici;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic [7:0] P;
   logic       busy;
   logic       done;

   int errors   = 0;
   int checks   = 0;
   int accepts  = 0;
   int done_cnt = 0;
   logic [7:0] p_prev = 8'd0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
      string      nm;
   } vec_t;

   vec_t vecs [8];

   seri_carpici #(.W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .P     (P),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every done pulse, sampled mid-cycle.
   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One complete multiply: accept, four busy cycles, done with product,
   // then back in IDLE with P held.
   task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input string nm);
      @(posedge clk); #1;
      start = 1'b1; A = a; B = b;
      @(posedge clk); #1;
      accepts++;
      start = 1'b0; A = 4'($urandom); B = 4'($urandom);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(posedge clk);
         @(negedge clk);
         chk({nm, " busy"}, int'(busy), (k < 4) ? 1 : 0);
         chk({nm, " done"}, int'(done), (k == 4) ? 1 : 0);
         chk({nm, " P"},    int'(P),    (k < 4) ? int'(p_prev) : int'(exp));
      end
      p_prev = exp;
   endtask

   initial begin
      vecs[0] = '{4'd15, 4'd15, 8'd225, "max15x15"};
      vecs[1] = '{4'd0,  4'd9,  8'd0,   "zero0x9"};
      vecs[2] = '{4'd9,  4'd0,  8'd0,   "zero9x0"};
      vecs[3] = '{4'd1,  4'd1,  8'd1,   "one1x1"};
      vecs[4] = '{4'd9,  4'd6,  8'd54,  "v9x6"};
      vecs[5] = '{4'd7,  4'd7,  8'd49,  "v7x7"};
      vecs[6] = '{4'd1,  4'd15, 8'd15,  "v1x15"};
      vecs[7] = '{4'd12, 4'd10, 8'd120, "v12x10"};

      rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
      #2;
      chk("reset P",    int'(P),    0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Table-driven directed vectors.
      for (int i = 0; i < 8; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].nm);

      // start while busy: second request must be ignored through CALC and DONE.
      @(posedge clk); #1;
      start = 1'b1; A = 4'd9; B = 4'd6;
      @(posedge clk); #1;
      accepts++;
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            if (k == 1) begin start = 1'b1; A = 4'd3; B = 4'd3; end
            if (k == 5) start = 1'b0;
         end
         @(negedge clk);
         chk("busystart busy", int'(busy), (k < 4) ? 1 : 0);
         chk("busystart done", int'(done), (k == 4) ? 1 : 0);
         chk("busystart P",    int'(P),    (k < 4) ? int'(p_prev) : 54);
      end
      p_prev = 8'd54;

      // Reset mid-operation: async clear, no done, P reads 0.
      @(posedge clk); #1;
      start = 1'b1; A = 4'd7; B = 4'd7;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst P",    int'(P),    0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst done", int'(done), 0);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("postrst done", int'(done), 0);
         chk("postrst busy", int'(busy), 0);
         chk("postrst P",    int'(P),    0);
      end
      p_prev = 8'd0;
      do_op(4'd1, 4'd1, 8'd1, "afterrst1x1");

      // Back-to-back with start held high: done pulses 6 cycles apart.
      @(posedge clk); #1;
      start = 1'b1; A = 4'd2; B = 4'd3;
      @(posedge clk); #1;
      accepts += 2;
      A = 4'd5; B = 4'd4;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            if (k == 10) start = 1'b0;
         end
         @(negedge clk);
         chk("b2b busy", int'(busy), ((k < 4) || (k >= 6 && k < 10)) ? 1 : 0);
         chk("b2b done", int'(done), (k == 4 || k == 10) ? 1 : 0);
         chk("b2b P",    int'(P),
             (k < 4) ? int'(p_prev) : ((k < 10) ? 6 : 20));
      end
      p_prev = 8'd20;

      // Exhaustive operand sweep.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            do_op(4'(a), 4'(b), 8'(a * b), "exh");

      @(negedge clk);
      chk("done count", done_cnt, accepts);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_seri_carpici
`default_nettype wire
